// File: rtl/generador_minterminos_if.sv
// Handshake bundle between a minterm consumer and generador_minterminos.
// The block drives the term stream and status; the consumer drives start,
// target and ready.
interface generador_minterminos_if;
    logic       inicio;
    logic       objetivo;
    logic       salida_listo;
    logic [3:0] termino;
    logic       termino_valido;
    logic       ocupado;
    logic       fin;
    logic [4:0] cuenta;

    // Consumer side: starts scans and accepts terms
    modport master (
        output inicio, objetivo, salida_listo,
        input  termino, termino_valido, ocupado, fin, cuenta
    );

    // Generator side
    modport slave (
        input  inicio, objetivo, salida_listo,
        output termino, termino_valido, ocupado, fin, cuenta
    );
endinterface

// File: rtl/generador_minterminos.sv
// Minterm generator: scans every 4-bit vector in ascending order and emits,
// through a valid/ready handshake, each one where
// f(x) = (x[1] & x[0]) | (x[3] & x[2]) equals the target latched at start.
// Each index costs one search cycle; each match adds one or more emit cycles.
module generador_minterminos (
    input  logic                          clk,
    input  logic                          reset,
    generador_minterminos_if.slave        bus
);

    typedef enum logic [1:0] {
        REPOSO,
        BUSCA,
        EMITE,
        FIN
    } estado_t;

    estado_t    estado;
    logic [3:0] indice;
    logic       objetivo_fijo;
    logic [3:0] termino;
    logic       termino_valido;
    logic       ocupado;
    logic       fin;
    logic [4:0] cuenta;
    logic       coincide;
    logic       acepta;

    function automatic logic funcion_f(input logic [3:0] x);
        return (x[1] & x[0]) | (x[3] & x[2]);
    endfunction

    // Current index matches the target latched at start
    assign coincide = (funcion_f(indice) == objetivo_fijo);

    // Consumer takes the pending term on this edge
    assign acepta = termino_valido & bus.salida_listo;

    // Scan sequencer; every output is a register updated with the state
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values and the update order inside the block is irrelevant.
        if (reset) begin
            estado         <= REPOSO;
            indice         <= 4'd0;
            objetivo_fijo  <= 1'b0;
            termino        <= 4'd0;
            termino_valido <= 1'b0;
            ocupado        <= 1'b0;
            fin            <= 1'b0;
            cuenta         <= 5'd0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (bus.inicio) begin
                        objetivo_fijo <= bus.objetivo;
                        indice        <= 4'd0;
                        cuenta        <= 5'd0;
                        ocupado       <= 1'b1;
                        estado        <= BUSCA;
                    end
                end

                BUSCA: begin
                    if (coincide) begin
                        termino        <= indice;
                        termino_valido <= 1'b1;
                        estado         <= EMITE;
                    end else if (indice == 4'd15) begin
                        // 15 is terminal: the index never wraps
                        fin    <= 1'b1;
                        estado <= FIN;
                    end else begin
                        indice <= indice + 4'd1;
                    end
                end

                EMITE: begin
                    // Term and valid stay frozen until the consumer accepts
                    if (acepta) begin
                        termino_valido <= 1'b0;
                        cuenta         <= cuenta + 5'd1;
                        if (indice == 4'd15) begin
                            fin    <= 1'b1;
                            estado <= FIN;
                        end else begin
                            indice <= indice + 4'd1;
                            estado <= BUSCA;
                        end
                    end
                end

                FIN: begin
                    fin     <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= REPOSO;
                end

                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

    assign bus.termino        = termino;
    assign bus.termino_valido = termino_valido;
    assign bus.ocupado        = ocupado;
    assign bus.fin            = fin;
    assign bus.cuenta         = cuenta;

endmodule

// File: tb/tb_generador_minterminos.sv
// Directed bench for generador_minterminos. Expected terms come from a
// truth-table model, are queued when a scan is started and popped as the
// generator hands terms over.
module tb_generador_minterminos;

    logic clk;
    logic reset;
    int   pasados;
    int   total;

    // Bit x is f(x); minterms of f are 3,7,11,12,13,14,15
    logic [15:0] tabla_f;

    generador_minterminos_if bus ();

    generador_minterminos dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pasados++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full scan: start pulse, optional stall on the first term,
    // optional start/target disturbance while busy.
    task automatic run_scan(input logic obj, input int demora, input bit perturbar, input string tag);
        logic [3:0] esperados[$];
        logic [3:0] exp_t;
        logic [3:0] k0;
        int  num;
        int  held;
        int  first_n;
        int  fin_n;
        int  fin_pulsos;
        int  violaciones;
        bit  primero_hecho;
        bit  valido_prev;
        bit  hs_prev;
        bit  hs;
        bit  visto_fin;

        num = 0;
        for (int x = 0; x < 16; x++) begin
            if (tabla_f[x] == obj) begin
                esperados.push_back(4'(x));
                num++;
            end
        end
        k0            = esperados[0];
        held          = 0;
        first_n       = -1;
        fin_n         = -1;
        fin_pulsos    = 0;
        violaciones   = 0;
        primero_hecho = 1'b0;
        valido_prev   = 1'b0;
        hs_prev       = 1'b0;
        visto_fin     = 1'b0;

        @(negedge clk);
        bus.objetivo     = obj;
        bus.inicio       = 1'b1;
        bus.salida_listo = 1'b1;

        for (int n = 1; n <= 100 && !visto_fin; n++) begin
            @(negedge clk);
            bus.inicio = 1'b0;
            if (perturbar && n == 2) begin
                bus.inicio   = 1'b1;
                bus.objetivo = ~obj;
            end
            if (valido_prev && !hs_prev && !bus.termino_valido) violaciones++;
            if (bus.termino_valido && first_n < 0) first_n = n;
            if (bus.termino_valido && !primero_hecho) begin
                held++;
                if (bus.termino !== k0) violaciones++;
                bus.salida_listo = (held > demora) ? 1'b1 : 1'b0;
            end else begin
                bus.salida_listo = 1'b1;
            end
            hs = bus.termino_valido && bus.salida_listo;
            if (hs) begin
                if (esperados.size() == 0) begin
                    check({tag, " extra term"}, 32'(bus.termino), 32'd99);
                end else begin
                    exp_t = esperados.pop_front();
                    check({tag, " termino"}, 32'(bus.termino), 32'(exp_t));
                end
                primero_hecho = 1'b1;
            end
            if (bus.fin) begin
                fin_pulsos++;
                visto_fin = 1'b1;
                fin_n     = n;
                check({tag, " ocupado in FIN"}, 32'(bus.ocupado), 32'd1);
                check({tag, " valid in FIN"}, 32'(bus.termino_valido), 32'd0);
            end
            valido_prev = bus.termino_valido;
            hs_prev     = hs;
        end

        check({tag, " scan finished"}, 32'(visto_fin), 32'd1);
        check({tag, " first valid cycle"}, 32'(first_n), 32'(k0) + 32'd2);
        check({tag, " fin cycle"}, 32'(fin_n), 32'(17 + num + demora));
        check({tag, " terms left"}, 32'(esperados.size()), 32'd0);
        check({tag, " first term hold cycles"}, 32'(held), 32'(demora + 1));
        check({tag, " handshake violations"}, 32'(violaciones), 32'd0);

        @(negedge clk);
        if (bus.fin) fin_pulsos++;
        check({tag, " fin pulses"}, 32'(fin_pulsos), 32'd1);
        check({tag, " ocupado after FIN"}, 32'(bus.ocupado), 32'd0);
        check({tag, " cuenta"}, 32'(bus.cuenta), 32'(num));
        repeat (2) @(negedge clk);
        check({tag, " cuenta held"}, 32'(bus.cuenta), 32'(num));
        bus.objetivo = obj;
    endtask

    initial begin
        int  fins;
        bit  encontrado;

        pasados          = 0;
        total            = 0;
        tabla_f          = 16'hF888;
        reset            = 1'b1;
        bus.inicio       = 1'b0;
        bus.objetivo     = 1'b0;
        bus.salida_listo = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset termino", 32'(bus.termino), 32'd0);
        check("reset valid", 32'(bus.termino_valido), 32'd0);
        check("reset ocupado", 32'(bus.ocupado), 32'd0);
        check("reset fin", 32'(bus.fin), 32'd0);
        check("reset cuenta", 32'(bus.cuenta), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Main function across both targets, stalls and disturbances
        run_scan(1'b1, 0, 1'b0, "obj1");
        run_scan(1'b0, 0, 1'b0, "obj0");
        run_scan(1'b1, 5, 1'b0, "stall");
        run_scan(1'b1, 0, 1'b1, "disturb");
        run_scan(1'b0, 2, 1'b1, "disturb0");

        // Reset while term 11 is pending aborts the scan without fin
        @(negedge clk);
        bus.objetivo     = 1'b1;
        bus.inicio       = 1'b1;
        bus.salida_listo = 1'b1;
        encontrado       = 1'b0;
        for (int n = 0; n < 60 && !encontrado; n++) begin
            @(negedge clk);
            bus.inicio = 1'b0;
            if (bus.termino_valido && bus.termino == 4'd11) encontrado = 1'b1;
        end
        check("abort term 11 reached", 32'(encontrado), 32'd1);
        bus.salida_listo = 1'b0;
        reset            = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort valid", 32'(bus.termino_valido), 32'd0);
        check("abort ocupado", 32'(bus.ocupado), 32'd0);
        check("abort cuenta", 32'(bus.cuenta), 32'd0);
        check("abort termino", 32'(bus.termino), 32'd0);
        fins = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.fin) fins++;
        end
        check("abort fin pulses", 32'(fins), 32'd0);
        check("abort idle", 32'(bus.ocupado), 32'd0);
        run_scan(1'b1, 0, 1'b0, "restart");

        // Start coincident with reset is dropped
        @(negedge clk);
        bus.inicio = 1'b1;
        reset      = 1'b1;
        @(negedge clk);
        bus.inicio = 1'b0;
        reset      = 1'b0;
        check("inicio+reset ocupado", 32'(bus.ocupado), 32'd0);
        check("inicio+reset valid", 32'(bus.termino_valido), 32'd0);
        @(negedge clk);
        check("inicio+reset stays idle", 32'(bus.ocupado), 32'd0);

        $display("%0d/%0d checks passed", pasados, total);
        $finish;
    end

endmodule
